ocx_dlx_tx_train_ctl: RTL and testbench
=======================================

Name: ocx_dlx_tx_train_ctl

Overview:
- Per-link TX training sequencer for the eight per-lane TX queue/scrambler slices.
- Drives the queue control bus: ctl_que_reset, ctl_que_stall, ctl_que_tx_ts0..3, good-lane mask, deskew count and neighbor-steal select.
- Walks the link through TS1/TS2/TS3 training from RX-side handshakes, then releases the lanes to flit traffic.
- Selects x8 or x4-degraded width from the negotiated good-lane mask.

Parameters:
- MIN_TS_CNT, 16, minimum non-stalled pattern cycles sent in each TS state before advancing.
- TIMEOUT_CYCLES, 24'd8000000, watchdog limit per training state (optional feature only).

Ports:
- dlx_clk  in  1  DLX clock.
- dlx_reset_n  in  1  synchronous active-low reset.
- start_train  in  1  level; 1 requests training, 0 holds or returns the link to reset.
- gb_stall  in  1  gearbox back-pressure; pattern/flit slot not consumed this cycle.
- rx_ts1_valid  in  1  RX locked on TS1 from partner.
- rx_ts2_valid  in  1  RX locked on TS2.
- rx_ts3_valid  in  1  RX locked on TS3.
- rx_good_lanes  in  16  partner good-lane mask; [7:0] meaningful, [15:8] must be 0.
- ctl_que_reset  out  1  to all que slices.
- ctl_que_stall  out  1  to all que slices.
- ctl_que_tx_ts0, ctl_que_tx_ts1, ctl_que_tx_ts2, ctl_que_tx_ts3  out  1 each  pattern selects.
- ctl_que_good_lanes  out  16  latched mask advertised in TS2/TS3.
- ctl_que_deskew  out  24  deskew block count.
- ctl_que_use_neighbor  out  8  per-lane neighbor-steal select.
- link_up  out  1  flit mode active.
- link_x4  out  1  degraded width.
- train_timeout  out  1  one-cycle pulse (optional feature only).

Behaviour:
- All outputs registered; 1-cycle latency from inputs, except ctl_que_stall = gb_stall registered (same 1-cycle latency as the rest).
- Reset (dlx_reset_n=0 at clock edge): state=RESET; ctl_que_reset=1; ts0..3=0; good_lanes=0; deskew=0; use_neighbor=0; link_up=0; link_x4=0; train_timeout=0.
- Advance rule: state transitions and pattern counters step only on cycles with gb_stall=0.
- Pattern counter is 5 bits, saturating at MIN_TS_CNT, and clears on every state change.

State machine:
- RESET: ctl_que_reset=1, ts0=1. Go to TS1 when start_train=1.
- TS1: ts1=1. Go to TS2 when count>=MIN_TS_CNT and rx_ts1_valid=1. On entry to TS2, latch ctl_que_good_lanes = rx_good_lanes.
- TS2: ts2=1. Go to TS3 when count>=MIN_TS_CNT and rx_ts2_valid=1, but only if the latched mask[7:0] is legal:
  - 8'hFF: x8.
  - 8'h0F: x4, use_neighbor=8'h00.
  - 8'hF0: x4, use_neighbor=8'hF0.
  - Any other mask: back to RESET.
- TS3: ts3=1. Go to FLIT when count>=MIN_TS_CNT and rx_ts3_valid=1.
- FLIT: all ts=0, link_up=1. link_x4 and use_neighbor hold their values from the TS2 exit.
- Exactly one of ts0..ts3 is high in RESET..TS3; none in FLIT.
- ctl_que_reset is high only in RESET.

Deskew counter:
- 24 bits; +1 on every non-stalled cycle outside RESET; 0 in RESET.
- Wraps 24'hFFFFFF -> 0 with no flag.

Abort and simultaneous events:
- start_train=0 in any state -> RESET next cycle, regardless of gb_stall. Clears good_lanes, use_neighbor, link_x4, link_up.
- Abort has priority over any same-cycle advance.
- An RX valid that drops before count saturates is not remembered; only the level at the advance cycle counts.
- Reset mid-state behaves identically to the abort path.
- gb_stall=1 for many cycles: hold state, counters and all outputs.

Optional Feature:
- Macro OCX_DLX_TX_TRAIN_TIMEOUT_EN.
- When defined:
  - 24-bit watchdog clears on every state change; counts every cycle in TS1/TS2/TS3.
  - Reaching TIMEOUT_CYCLES forces RESET and pulses train_timeout for 1 cycle.
  - RESET then re-enters TS1 next cycle if start_train is still 1.
- When undefined: no watchdog logic; train_timeout port absent.

Decomposition:
- Package ocx_dlx_tx_train_pkg:
  - state enum (RESET, TS1, TS2, TS3, FLIT).
  - Legal mask constants: 8'hFF, 8'h0F, 8'hF0.
  - MIN_TS_CNT default.
- One sub-module: ocx_dlx_tx_lane_width_dec. Combinational mask[7:0] -> {legal, x4, use_neighbor[7:0]}.

Test Plan:
- Reset then start_train=1, all rx_ts*_valid=1, mask 8'hFF, no stall -> TS1 16 cycles, TS2 16, TS3 16; link_up=1 on cycle 50 after start; link_x4=0; use_neighbor=8'h00.
- Same flow with gb_stall=1 every other cycle -> each TS state lasts 32 cycles; deskew advances only on non-stalled cycles.
- Mask 8'hF0 -> link_x4=1, use_neighbor=8'hF0 after TS2 exit. Mask 8'h3C -> return to RESET after 16 TS2 cycles, ctl_que_reset=1.
- start_train dropped in TS3 while rx_ts3_valid=1 and count saturated -> RESET wins; link_up stays 0; good_lanes=0.
- Deskew wrap: force count to 24'hFFFFFE in FLIT, two unstalled cycles -> 24'h000000 with no disturbance to state.
- With OCX_DLX_TX_TRAIN_TIMEOUT_EN, TIMEOUT_CYCLES=100, rx_ts1_valid=0 -> RESET at cycle 100 of TS1; one-cycle train_timeout pulse; re-enters TS1.

Source files
------------

// File: rtl/ocx_dlx_tx_train_ctl_pkg.sv
// Shared types and constants for the DLX TX training sequencer.
// Holds the training state encoding, the legal good-lane masks and the default pattern count.
package ocx_dlx_tx_train_pkg;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_TS1   = 3'd1,
        ST_TS2   = 3'd2,
        ST_TS3   = 3'd3,
        ST_FLIT  = 3'd4
    } train_state_t;

    localparam logic [7:0] MASK_X8    = 8'hFF;
    localparam logic [7:0] MASK_X4_LO = 8'h0F;
    localparam logic [7:0] MASK_X4_HI = 8'hF0;

    localparam int MIN_TS_CNT_DEF = 16;

endpackage

// File: rtl/ocx_dlx_tx_train_ctl_if.sv
// Training control bus between the sequencer (master) and the RX side / que slices (slave).
// train_timeout exists only when OCX_DLX_TX_TRAIN_TIMEOUT_EN is defined.
interface ocx_dlx_tx_train_ctl_if;
    logic        start_train;
    logic        gb_stall;
    logic        rx_ts1_valid;
    logic        rx_ts2_valid;
    logic        rx_ts3_valid;
    logic [15:0] rx_good_lanes;
    logic        ctl_que_reset;
    logic        ctl_que_stall;
    logic        ctl_que_tx_ts0;
    logic        ctl_que_tx_ts1;
    logic        ctl_que_tx_ts2;
    logic        ctl_que_tx_ts3;
    logic [15:0] ctl_que_good_lanes;
    logic [23:0] ctl_que_deskew;
    logic [7:0]  ctl_que_use_neighbor;
    logic        link_up;
    logic        link_x4;
`ifdef OCX_DLX_TX_TRAIN_TIMEOUT_EN
    logic        train_timeout;
`endif

    modport master (
        input  start_train, gb_stall, rx_ts1_valid, rx_ts2_valid, rx_ts3_valid, rx_good_lanes,
        output ctl_que_reset, ctl_que_stall, ctl_que_tx_ts0, ctl_que_tx_ts1, ctl_que_tx_ts2,
        output ctl_que_tx_ts3, ctl_que_good_lanes, ctl_que_deskew, ctl_que_use_neighbor,
        output link_up, link_x4
`ifdef OCX_DLX_TX_TRAIN_TIMEOUT_EN
        , output train_timeout
`endif
    );

    modport slave (
        output start_train, gb_stall, rx_ts1_valid, rx_ts2_valid, rx_ts3_valid, rx_good_lanes,
        input  ctl_que_reset, ctl_que_stall, ctl_que_tx_ts0, ctl_que_tx_ts1, ctl_que_tx_ts2,
        input  ctl_que_tx_ts3, ctl_que_good_lanes, ctl_que_deskew, ctl_que_use_neighbor,
        input  link_up, link_x4
`ifdef OCX_DLX_TX_TRAIN_TIMEOUT_EN
        , input train_timeout
`endif
    );
endinterface

// File: rtl/ocx_dlx_tx_train_ctl_width_dec.sv
// Combinational good-lane mask decode: legal width, x4 degrade and neighbor-steal select.
// Zero latency; no flow control.
module ocx_dlx_tx_lane_width_dec
    import ocx_dlx_tx_train_pkg::*;
(
    input  logic [7:0] mask,
    output logic       legal,
    output logic       x4,
    output logic [7:0] use_neighbor
);
    always_comb begin
        legal        = 1'b0;
        x4           = 1'b0;
        use_neighbor = 8'h00;
        case (mask)
            MASK_X8: legal = 1'b1;
            MASK_X4_LO: begin
                legal = 1'b1;
                x4    = 1'b1;
            end
            // Upper half survives: its lanes steal from their lower neighbours.
            MASK_X4_HI: begin
                legal        = 1'b1;
                x4           = 1'b1;
                use_neighbor = MASK_X4_HI;
            end
            default: legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/ocx_dlx_tx_train_ctl.sv
// TX training sequencer RESET->TS1->TS2->TS3->FLIT; every output registered, 1-cycle latency.
// gb_stall freezes state/counters/outputs; start_train=0 aborts to RESET. Watchdog: OCX_DLX_TX_TRAIN_TIMEOUT_EN.
module ocx_dlx_tx_train_ctl
    import ocx_dlx_tx_train_pkg::*;
#(
    parameter int MIN_TS_CNT = MIN_TS_CNT_DEF
`ifdef OCX_DLX_TX_TRAIN_TIMEOUT_EN
    ,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd8000000
`endif
) (
    input  logic                  dlx_clk,
    input  logic                  dlx_reset_n,
    ocx_dlx_tx_train_ctl_if.master bus
);
    // The count tracks completed pattern cycles, so the current cycle is the (cnt_q+1)-th.
    localparam logic [4:0] CNT_SAT = 5'(MIN_TS_CNT);
    localparam logic [4:0] CNT_ADV = 5'(MIN_TS_CNT - 1);

    train_state_t state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [23:0]  deskew_q, deskew_d;
    logic [15:0]  good_q, good_d;
    logic [7:0]   nbr_q, nbr_d;
    logic         x4_q, x4_d;
    logic         up_q, up_d;
    logic         rst_q, rst_d;
    logic [3:0]   ts_q, ts_d;
    logic         stall_q;
    logic         cnt_done;
    logic         dec_legal, dec_x4;
    logic [7:0]   dec_nbr;

    ocx_dlx_tx_lane_width_dec u_width_dec (
        .mask         (good_q[7:0]),
        .legal        (dec_legal),
        .x4           (dec_x4),
        .use_neighbor (dec_nbr)
    );

    assign cnt_done = (cnt_q >= CNT_ADV);

`ifdef OCX_DLX_TX_TRAIN_TIMEOUT_EN
    logic [23:0] wd_q, wd_d;
    logic        to_q, to_d;
    logic        in_ts;
    logic        wd_expire;

    assign in_ts     = (state_q == ST_TS1) || (state_q == ST_TS2) || (state_q == ST_TS3);
    assign wd_expire = in_ts && (wd_q == TIMEOUT_CYCLES - 24'd1);
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        deskew_d = deskew_q;
        good_d   = good_q;
        nbr_d    = nbr_q;
        x4_d     = x4_q;
`ifdef OCX_DLX_TX_TRAIN_TIMEOUT_EN
        to_d     = 1'b0;
`endif
        if (!bus.start_train) begin
            state_d = ST_RESET;
`ifdef OCX_DLX_TX_TRAIN_TIMEOUT_EN
        end else if (wd_expire) begin
            state_d = ST_RESET;
            to_d    = 1'b1;
`endif
        end else if (!bus.gb_stall) begin
            case (state_q)
                ST_RESET: state_d = ST_TS1;
                ST_TS1: if (cnt_done && bus.rx_ts1_valid) begin
                    state_d = ST_TS2;
                    good_d  = bus.rx_good_lanes;
                end
                ST_TS2: if (cnt_done && bus.rx_ts2_valid) begin
                    state_d = dec_legal ? ST_TS3 : ST_RESET;
                    x4_d    = dec_x4;
                    nbr_d   = dec_nbr;
                end
                ST_TS3: if (cnt_done && bus.rx_ts3_valid) state_d = ST_FLIT;
                default: state_d = state_q;
            endcase
            if (state_d != state_q)   cnt_d = '0;
            else if (cnt_q != CNT_SAT) cnt_d = cnt_q + 5'd1;
            deskew_d = (state_q == ST_RESET) ? 24'd0 : deskew_q + 24'd1;
        end
        if (state_d == ST_RESET) begin
            cnt_d    = '0;
            deskew_d = '0;
            good_d   = '0;
            nbr_d    = '0;
            x4_d     = 1'b0;
        end
    end

    always_comb begin
        rst_d = (state_d == ST_RESET);
        up_d  = (state_d == ST_FLIT);
        ts_d  = 4'b0000;
        case (state_d)
            ST_RESET: ts_d = 4'b0001;
            ST_TS1:   ts_d = 4'b0010;
            ST_TS2:   ts_d = 4'b0100;
            ST_TS3:   ts_d = 4'b1000;
            default:  ts_d = 4'b0000;
        endcase
    end

`ifdef OCX_DLX_TX_TRAIN_TIMEOUT_EN
    always_comb begin
        wd_d = '0;
        if (in_ts && (state_d == state_q)) wd_d = wd_q + 24'd1;
    end
`endif

    always_ff @(posedge dlx_clk) begin
        if (!dlx_reset_n) begin
            state_q  <= ST_RESET;
            cnt_q    <= '0;
            deskew_q <= '0;
            good_q   <= '0;
            nbr_q    <= '0;
            x4_q     <= 1'b0;
            up_q     <= 1'b0;
            rst_q    <= 1'b1;
            ts_q     <= '0;
            stall_q  <= 1'b0;
`ifdef OCX_DLX_TX_TRAIN_TIMEOUT_EN
            wd_q     <= '0;
            to_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            deskew_q <= deskew_d;
            good_q   <= good_d;
            nbr_q    <= nbr_d;
            x4_q     <= x4_d;
            up_q     <= up_d;
            rst_q    <= rst_d;
            ts_q     <= ts_d;
            stall_q  <= bus.gb_stall;
`ifdef OCX_DLX_TX_TRAIN_TIMEOUT_EN
            wd_q     <= wd_d;
            to_q     <= to_d;
`endif
        end
    end

    assign bus.ctl_que_reset        = rst_q;
    assign bus.ctl_que_stall        = stall_q;
    assign bus.ctl_que_tx_ts0       = ts_q[0];
    assign bus.ctl_que_tx_ts1       = ts_q[1];
    assign bus.ctl_que_tx_ts2       = ts_q[2];
    assign bus.ctl_que_tx_ts3       = ts_q[3];
    assign bus.ctl_que_good_lanes   = good_q;
    assign bus.ctl_que_deskew       = deskew_q;
    assign bus.ctl_que_use_neighbor = nbr_q;
    assign bus.link_up              = up_q;
    assign bus.link_x4              = x4_q;
`ifdef OCX_DLX_TX_TRAIN_TIMEOUT_EN
    assign bus.train_timeout        = to_q;
`endif
endmodule

// File: tb/tb_ocx_dlx_tx_train_ctl.sv
// Bench for ocx_dlx_tx_train_ctl: directed training scenarios plus random stimulus
// checked every cycle against a phase/pattern-count reference model.
module tb_ocx_dlx_tx_train_ctl;
    localparam int MIN_TS = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ocx_dlx_tx_train_ctl_if u_if ();

    ocx_dlx_tx_train_ctl #(.MIN_TS_CNT(MIN_TS)) u_dut (
        .dlx_clk     (clk),
        .dlx_reset_n (rst_n),
        .bus         (u_if)
    );

    // Model: phase 0..4 = RESET,TS1,TS2,TS3,FLIT; m_sent = pattern cycles sent in the phase.
    int          m_phase;
    int          m_sent;
    logic [23:0] m_deskew;
    logic [15:0] m_lanes;
    logic [7:0]  m_nbr;
    logic        m_x4;
    logic        m_stall;
    logic        m_fresh;

    task automatic mdl_step();
        int np;
        np = m_phase;
        if (!rst_n) begin
            m_phase = 0; m_sent = 0; m_deskew = '0; m_lanes = '0;
            m_nbr = '0; m_x4 = 1'b0; m_stall = 1'b0; m_fresh = 1'b1;
            return;
        end
        m_fresh = 1'b0;
        m_stall = u_if.gb_stall;
        if (!u_if.start_train) begin
            np = 0;
        end else if (u_if.gb_stall) begin
            return;
        end else begin
            m_sent = m_sent + 1;
            case (m_phase)
                0: np = 1;
                1: if (m_sent >= MIN_TS && u_if.rx_ts1_valid) begin
                    np = 2;
                    m_lanes = u_if.rx_good_lanes;
                end
                2: if (m_sent >= MIN_TS && u_if.rx_ts2_valid) begin
                    if (m_lanes[7:0] inside {8'hFF, 8'h0F, 8'hF0}) begin
                        np = 3;
                        m_x4 = (m_lanes[7:0] != 8'hFF);
                        m_nbr = (m_lanes[7:0] == 8'hF0) ? 8'hF0 : 8'h00;
                    end else begin
                        np = 0;
                    end
                end
                3: if (m_sent >= MIN_TS && u_if.rx_ts3_valid) np = 4;
                default: np = m_phase;
            endcase
            m_deskew = (m_phase == 0) ? 24'd0 : m_deskew + 24'd1;
        end
        if (np != m_phase) m_sent = 0;
        m_phase = np;
        if (m_phase == 0) begin
            m_deskew = '0; m_lanes = '0; m_nbr = '0; m_x4 = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        logic [7:0] exp_ctl, obs_ctl;
        exp_ctl = {m_phase == 0, (m_phase == 0) && !m_fresh, m_phase == 1, m_phase == 2,
                   m_phase == 3, m_phase == 4, m_x4, m_stall};
        obs_ctl = {u_if.ctl_que_reset, u_if.ctl_que_tx_ts0, u_if.ctl_que_tx_ts1, u_if.ctl_que_tx_ts2,
                   u_if.ctl_que_tx_ts3, u_if.link_up, u_if.link_x4, u_if.ctl_que_stall};
        chk({ctx, "/ctl"}, 32'(obs_ctl), 32'(exp_ctl));
        chk({ctx, "/good_lanes"}, 32'(u_if.ctl_que_good_lanes), 32'(m_lanes));
        chk({ctx, "/deskew"}, 32'(u_if.ctl_que_deskew), 32'(m_deskew));
        chk({ctx, "/use_neighbor"}, 32'(u_if.ctl_que_use_neighbor), 32'(m_nbr));
    endtask

    task automatic cyc(input string ctx);
        @(posedge clk);
        mdl_step();
        #1;
        check_all(ctx);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        u_if.start_train = 1'b0; u_if.gb_stall = 1'b0;
        u_if.rx_ts1_valid = 1'b0; u_if.rx_ts2_valid = 1'b0; u_if.rx_ts3_valid = 1'b0;
        u_if.rx_good_lanes = '0;
        repeat (3) cyc("reset");
        rst_n = 1'b1;
        cyc("idle");
    endtask

    // Edge numbering: edge 1 is the first clock edge that samples start_train=1.
    task automatic run_flow(input logic [7:0] mask, input bit alt, input string ctx, output int up_edge);
        up_edge = -1;
        u_if.rx_good_lanes = {8'h00, mask};
        u_if.rx_ts1_valid = 1'b1; u_if.rx_ts2_valid = 1'b1; u_if.rx_ts3_valid = 1'b1;
        u_if.start_train = 1'b1;
        for (int e = 1; e <= 200 && up_edge < 0; e++) begin
            u_if.gb_stall = alt && (e % 2 == 0);
            cyc(ctx);
            if (u_if.link_up === 1'b1) up_edge = e;
        end
        u_if.gb_stall = 1'b0;
    endtask

    initial begin
        int up;
        logic [7:0] pick;

        rst_n = 1'b0;
        u_if.start_train = 1'b0; u_if.gb_stall = 1'b0;
        u_if.rx_ts1_valid = 1'b0; u_if.rx_ts2_valid = 1'b0; u_if.rx_ts3_valid = 1'b0;
        u_if.rx_good_lanes = '0;
        repeat (3) cyc("reset");
        chk("rst_que_reset", 32'(u_if.ctl_que_reset), 32'd1);
        chk("rst_ts", 32'({u_if.ctl_que_tx_ts0, u_if.ctl_que_tx_ts1, u_if.ctl_que_tx_ts2, u_if.ctl_que_tx_ts3}), 32'd0);
        chk("rst_link", 32'({u_if.link_up, u_if.link_x4}), 32'd0);
        rst_n = 1'b1;
        cyc("idle");
        chk("idle_ts0", 32'(u_if.ctl_que_tx_ts0), 32'd1);

        run_flow(8'hFF, 1'b0, "x8", up);
        chk("x8_up_edge", 32'(up), 32'd49);
        chk("x8_width", 32'({u_if.link_x4, u_if.ctl_que_use_neighbor}), 32'd0);
        chk("x8_deskew", 32'(u_if.ctl_que_deskew), 32'd48);

        do_reset();
        run_flow(8'hFF, 1'b1, "stall", up);
        chk("stall_up_edge", 32'(up), 32'd97);
        chk("stall_deskew", 32'(u_if.ctl_que_deskew), 32'd48);

        do_reset();
        run_flow(8'hF0, 1'b0, "x4hi", up);
        chk("x4hi_up_edge", 32'(up), 32'd49);
        chk("x4hi_width", 32'({u_if.link_x4, u_if.ctl_que_use_neighbor}), 32'h1F0);
        chk("x4hi_lanes", 32'(u_if.ctl_que_good_lanes), 32'h00F0);

        do_reset();
        run_flow(8'h0F, 1'b0, "x4lo", up);
        chk("x4lo_width", 32'({u_if.link_x4, u_if.ctl_que_use_neighbor}), 32'h100);

        do_reset();
        u_if.rx_good_lanes = 16'h003C;
        u_if.rx_ts1_valid = 1'b1; u_if.rx_ts2_valid = 1'b1; u_if.rx_ts3_valid = 1'b1;
        u_if.start_train = 1'b1;
        for (int e = 1; e <= 34; e++) begin
            cyc("badmask");
            if (e == 17) chk("badmask_latched", 32'(u_if.ctl_que_good_lanes), 32'h003C);
            if (e == 33) chk("badmask_reset", 32'({u_if.ctl_que_reset, u_if.ctl_que_tx_ts0, u_if.ctl_que_good_lanes}), 32'h30000);
            if (e == 34) chk("badmask_retry_ts1", 32'(u_if.ctl_que_tx_ts1), 32'd1);
        end

        do_reset();
        u_if.rx_good_lanes = 16'h00FF;
        u_if.rx_ts1_valid = 1'b1; u_if.rx_ts2_valid = 1'b1; u_if.rx_ts3_valid = 1'b1;
        u_if.start_train = 1'b1;
        for (int e = 1; e <= 48; e++) cyc("abort");
        chk("abort_in_ts3", 32'(u_if.ctl_que_tx_ts3), 32'd1);
        u_if.start_train = 1'b0;
        cyc("abort");
        chk("abort_wins", 32'({u_if.link_up, u_if.ctl_que_reset, u_if.ctl_que_good_lanes}), 32'h10000);

        do_reset();
        run_flow(8'hFF, 1'b0, "wrap", up);
        force u_dut.deskew_q = 24'hFFFFFE;
        m_deskew = 24'hFFFFFE;
        #1;
        release u_dut.deskew_q;
        chk("wrap_preload", 32'(u_if.ctl_que_deskew), 32'h00FFFFFE);
        cyc("wrap");
        chk("wrap_max", 32'(u_if.ctl_que_deskew), 32'h00FFFFFF);
        cyc("wrap");
        chk("wrap_zero", 32'({u_if.link_up, u_if.ctl_que_deskew}), 32'h01000000);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            u_if.start_train = ($urandom_range(0, 149) != 0);
            u_if.gb_stall = ($urandom_range(0, 3) == 0);
            u_if.rx_ts1_valid = ($urandom_range(0, 5) != 0);
            u_if.rx_ts2_valid = ($urandom_range(0, 5) != 0);
            u_if.rx_ts3_valid = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 63) == 0) begin
                case ($urandom_range(0, 4))
                    0: pick = 8'hFF;
                    1: pick = 8'h0F;
                    2: pick = 8'hF0;
                    3: pick = 8'($urandom);
                    default: pick = 8'hFF;
                endcase
                u_if.rx_good_lanes = {8'h00, pick};
            end
            cyc("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete checks=%0d errors=%0d", checks, errors);
        $fatal(1, "time limit reached");
    end
endmodule
